// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register forwarding-latency counters plus a busy counter for the multi-cycle unit.
// Stall is combinational from ID inputs and registered state; a stalled instruction holds in ID until every hazard drains.
module id_hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int LW   = 3,
    parameter int MCW  = 5,
    parameter int PCW  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [AW-1:0]   rs1Addr_id,
    input  logic [AW-1:0]   rs2Addr_id,
    input  logic [AW-1:0]   rdAddr_id,
    input  logic [LW-1:0]   lat_id,
    input  logic            mc_id,
    input  logic [MCW-1:0]  mc_cycles_id,
    input  logic            flush_ex,
    output logic            Stall,
    output logic            IFWrite,
    output logic            issue_fire,
    output logic [NREG-1:0] busy_vec,
    output logic [PCW-1:0]  stall_count
);

    logic [LW-1:0]  r_cnt [NREG-1:1];
    logic [MCW-1:0] r_mc_cnt;
    logic [AW-1:0]  r_last_rd;
    logic           r_last_mc;
    logic [PCW-1:0] r_stall_count;

    logic [LW-1:0]  w_cnt_nxt [NREG-1:1];
    logic [MCW-1:0] w_mc_nxt;
    logic [LW-1:0]  w_rs1_cnt;
    logic [LW-1:0]  w_rs2_cnt;
    logic [LW-1:0]  w_rd_cnt;
    logic           w_raw;
    logic           w_waw;
    logic           w_struct;
    logic           w_stall;
    logic           w_fire;

    // Entry 0 and any address beyond NREG-1 read as an idle counter.
    always_comb begin
        w_rs1_cnt = '0;
        w_rs2_cnt = '0;
        w_rd_cnt  = '0;
        for (int r = 1; r < NREG; r++) begin
            if (rs1Addr_id == AW'(r)) w_rs1_cnt = r_cnt[r];
            if (rs2Addr_id == AW'(r)) w_rs2_cnt = r_cnt[r];
            if (rdAddr_id  == AW'(r)) w_rd_cnt  = r_cnt[r];
        end
    end

    assign w_raw    = (w_rs1_cnt != '0) || (w_rs2_cnt != '0);
    assign w_waw    = (w_rd_cnt > lat_id);
    assign w_struct = mc_id && (r_mc_cnt != '0);
    assign w_stall  = issue_valid && (w_raw || w_waw || w_struct);
    assign w_fire   = issue_valid && !w_stall && rst_n;

    assign Stall       = w_stall;
    assign IFWrite     = !w_stall;
    assign issue_fire  = w_fire;
    assign stall_count = r_stall_count;

    // Priority per entry: decrement, then flush of the killed EX instruction, then a new issue.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            w_cnt_nxt[r] = (r_cnt[r] != '0) ? r_cnt[r] - LW'(1) : '0;
            if (flush_ex && (r_last_rd == AW'(r)))
                w_cnt_nxt[r] = '0;
            if (w_fire && (rdAddr_id == AW'(r)) && (lat_id != '0))
                w_cnt_nxt[r] = lat_id;
        end
        w_mc_nxt = (r_mc_cnt != '0) ? r_mc_cnt - MCW'(1) : '0;
        if (flush_ex && r_last_mc)
            w_mc_nxt = '0;
        if (w_fire && mc_id)
            w_mc_nxt = mc_cycles_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREG; r++)
                r_cnt[r] <= '0;
            r_mc_cnt      <= '0;
            r_last_rd     <= '0;
            r_last_mc     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            for (int r = 1; r < NREG; r++)
                r_cnt[r] <= w_cnt_nxt[r];
            r_mc_cnt  <= w_mc_nxt;
            // A cycle without an accepted issue leaves a bubble in EX, so there is nothing to flush.
            r_last_rd <= w_fire ? rdAddr_id : '0;
            r_last_mc <= w_fire && mc_id;
            if (w_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + PCW'(1);
        end
    end

    assign busy_vec[0] = 1'b0;
    for (genvar g = 1; g < NREG; g++) begin : g_busy
        assign busy_vec[g] = (r_cnt[g] != '0);
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: directed scenarios plus randomized traffic against a ready-time model.
module tb_id_hazard_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int LW   = 3;
    localparam int MCW  = 5;
    localparam int PCW  = 8;
    localparam int SAT  = (1 << PCW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            issue_valid;
    logic [AW-1:0]   rs1, rs2, rd;
    logic [LW-1:0]   lat;
    logic            mc;
    logic [MCW-1:0]  mcc;
    logic            flush;
    logic            Stall, IFWrite, issue_fire;
    logic [NREG-1:0] busy_vec;
    logic [PCW-1:0]  stall_count;

    int vectors = 0;
    int errors  = 0;

    // Model: absolute cycle at which each register / the mc unit becomes free.
    longint now;
    longint ready_at [NREG];
    longint mc_free;
    int     last_rd;
    bit     last_mc;
    int     m_cnt;
    bit     prev_fire;
    bit              exp_stall, exp_fire;
    logic [NREG-1:0] exp_busy;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.NREG(NREG), .AW(AW), .LW(LW), .MCW(MCW), .PCW(PCW)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .rs1Addr_id(rs1), .rs2Addr_id(rs2), .rdAddr_id(rd), .lat_id(lat),
        .mc_id(mc), .mc_cycles_id(mcc), .flush_ex(flush),
        .Stall(Stall), .IFWrite(IFWrite), .issue_fire(issue_fire),
        .busy_vec(busy_vec), .stall_count(stall_count)
    );

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        mc_free = 0; last_rd = 0; last_mc = 0; m_cnt = 0; prev_fire = 0;
    endtask

    task automatic model_eval();
        bit raw, waw, st;
        longint l;
        l   = lat;
        raw = (rs1 != 0 && now < ready_at[rs1]) || (rs2 != 0 && now < ready_at[rs2]);
        waw = (rd != 0) && (ready_at[rd] - now > l);
        st  = mc && (now < mc_free);
        exp_stall = issue_valid && (raw || waw || st);
        exp_fire  = issue_valid && !exp_stall;
        for (int r = 0; r < NREG; r++) exp_busy[r] = (r != 0) && (now < ready_at[r]);
    endtask

    task automatic drive(input bit v, input int a1, input int a2, input int d, input int l,
                         input bit m, input int mcy, input bit fl);
        issue_valid = v; rs1 = a1[AW-1:0]; rs2 = a2[AW-1:0]; rd = d[AW-1:0];
        lat = l[LW-1:0]; mc = m; mcc = mcy[MCW-1:0]; flush = fl;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        longint l;
        @(posedge clk);
        l = lat;
        if (exp_stall && m_cnt != SAT) m_cnt++;
        if (flush) begin
            if (last_rd != 0 && ready_at[last_rd] > now + 1) ready_at[last_rd] = now + 1;
            if (last_mc && mc_free > now + 1) mc_free = now + 1;
        end
        if (exp_fire && rd != 0 && lat != 0) ready_at[rd] = now + 1 + l;
        if (exp_fire && mc) mc_free = now + 1 + longint'(mcc);
        last_rd   = exp_fire ? int'(rd) : 0;
        last_mc   = exp_fire && mc;
        prev_fire = exp_fire;
        now++;
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin sample(); tick(); end
    endtask

    task automatic test_reset();
        drive(1, 3, 4, 5, 1, 1, 5, 0);
        #2;
        vectors++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
        vectors++; if (IFWrite !== 1'b1) begin errors++; $display("FAIL reset_ifwrite: got %b want 1", IFWrite); end
        vectors++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL reset_fire: got %b want 0", issue_fire); end
        vectors++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        vectors++; if (stall_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", stall_count); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        now = 1; model_clear();
    endtask

    task automatic test_load_use();
        int base;
        idle(10);
        base = m_cnt;
        drive(1, 0, 0, 5, 1, 0, 0, 0);
        sample();
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL lu_load_fire: got %b want 1", issue_fire); end
        tick();
        drive(1, 5, 0, 6, 0, 0, 0, 0);
        sample();
        vectors++; if (Stall !== 1'b1 || issue_fire !== 1'b0) begin errors++; $display("FAIL lu_bubble: stall=%b fire=%b want 1/0", Stall, issue_fire); end
        tick();
        sample();
        vectors++; if (Stall !== 1'b0 || issue_fire !== 1'b1) begin errors++; $display("FAIL lu_proceed: stall=%b fire=%b want 0/1", Stall, issue_fire); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        vectors++; if (stall_count !== PCW'(base + 1)) begin errors++; $display("FAIL lu_count: got %0d want %0d", stall_count, base + 1); end
        tick();
    endtask

    task automatic test_mul_latency();
        idle(10);
        drive(1, 0, 0, 7, 3, 0, 0, 0);
        sample(); tick();
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            sample();
            vectors++;
            if (Stall !== (k < 4) || issue_fire !== (k == 4) || busy_vec[7] !== (k < 4)) begin
                errors++;
                $display("FAIL mul_dep t+%0d: stall=%b fire=%b busy7=%b want %b/%b/%b",
                         k, Stall, issue_fire, busy_vec[7], k < 4, k == 4, k < 4);
            end
            tick();
        end
    endtask

    task automatic test_mc_unit();
        idle(10);
        drive(1, 0, 0, 0, 0, 1, 10, 0);
        sample(); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        sample();
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL mc_alu_fire: got %b want 1", issue_fire); end
        drive(1, 0, 0, 0, 0, 1, 10, 0);
        #1; model_eval();
        vectors++; if (Stall !== 1'b1) begin errors++; $display("FAIL mc_div2 t+1: stall=%b want 1", Stall); end
        tick();
        for (int k = 2; k <= 11; k++) begin
            sample();
            vectors++;
            if (Stall !== (k < 11) || issue_fire !== (k == 11)) begin
                errors++;
                $display("FAIL mc_div2 t+%0d: stall=%b fire=%b want %b/%b", k, Stall, issue_fire, k < 11, k == 11);
            end
            tick();
        end
    endtask

    task automatic test_waw();
        idle(12);
        drive(1, 0, 0, 3, 3, 0, 0, 0);
        sample(); tick();
        drive(1, 0, 0, 3, 3, 0, 0, 0);
        sample();
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL waw_equal_lat: fire=%b want 1", issue_fire); end
        drive(1, 0, 0, 3, 0, 0, 0, 0);
        #1; model_eval();
        tick();
        for (int k = 2; k <= 4; k++) begin
            sample();
            vectors++;
            if (Stall !== (k < 4) || issue_fire !== (k == 4)) begin
                errors++;
                $display("FAIL waw_alu t+%0d: stall=%b fire=%b want %b/%b", k, Stall, issue_fire, k < 4, k == 4);
            end
            tick();
        end
        idle(8);
        drive(1, 0, 0, 3, 3, 0, 0, 0);
        sample(); tick();
        drive(1, 0, 0, 3, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            sample();
            vectors++;
            if (Stall !== (k < 4)) begin errors++; $display("FAIL waw_alu_direct t+%0d: stall=%b want %b", k, Stall, k < 4); end
            tick();
        end
    endtask

    task automatic test_x0();
        idle(10);
        drive(1, 0, 0, 0, 7, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            sample();
            vectors++;
            if (Stall !== 1'b0 || issue_fire !== 1'b1 || busy_vec !== '0) begin
                errors++;
                $display("FAIL x0 cyc %0d: stall=%b fire=%b busy=%h want 0/1/0", k, Stall, issue_fire, busy_vec);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        idle(10);
        drive(1, 0, 0, 9, 5, 0, 0, 0);
        sample(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        sample();
        vectors++; if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL flush_pre: busy9=%b want 1", busy_vec[9]); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        vectors++; if (busy_vec[9] !== 1'b0) begin errors++; $display("FAIL flush_clear: busy9=%b want 0", busy_vec[9]); end
        tick();
        drive(1, 0, 0, 9, 5, 0, 0, 0);
        sample(); tick();
        drive(1, 0, 0, 9, 6, 0, 0, 1);
        sample();
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL flush_reissue_fire: fire=%b want 1", issue_fire); end
        tick();
        drive(1, 9, 0, 0, 0, 0, 0, 0);
        sample();
        vectors++; if (busy_vec[9] !== 1'b1 || Stall !== 1'b1) begin errors++; $display("FAIL flush_reissue_keep: busy9=%b stall=%b want 1/1", busy_vec[9], Stall); end
        tick();
        idle(8);
        drive(1, 0, 0, 0, 0, 1, 20, 0);
        sample(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        sample(); tick();
        drive(1, 0, 0, 0, 0, 1, 3, 0);
        sample();
        vectors++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL flush_mc: fire=%b want 1", issue_fire); end
        tick();
    endtask

    task automatic test_random();
        idle(35);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 5) == 0,
                  $urandom_range(1, 12), prev_fire && ($urandom_range(0, 5) == 0));
            sample();
            vectors++;
            if (Stall !== exp_stall || IFWrite !== !exp_stall || issue_fire !== exp_fire ||
                busy_vec !== exp_busy || stall_count !== PCW'(m_cnt)) begin
                errors++;
                $display("FAIL random %0d: stall=%b fire=%b busy=%h cnt=%0d want stall=%b fire=%b busy=%h cnt=%0d",
                         i, Stall, issue_fire, busy_vec, stall_count, exp_stall, exp_fire, exp_busy, m_cnt);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        idle(35);
        for (int i = 0; i < 400; i++) begin
            drive(1, 0, 0, 0, 0, 1, 31, 0);
            sample();
            vectors++;
            if (Stall !== exp_stall || stall_count !== PCW'(m_cnt)) begin
                errors++;
                $display("FAIL sat %0d: stall=%b cnt=%0d want %b/%0d", i, Stall, stall_count, exp_stall, m_cnt);
            end
            tick();
        end
        idle(35);
        vectors++; if (stall_count !== PCW'(SAT)) begin errors++; $display("FAIL sat_hold: got %0d want %0d", stall_count, SAT); end
    endtask

    task automatic test_reset_mid_stall();
        idle(10);
        drive(1, 0, 0, 4, 7, 0, 0, 0);
        sample(); tick();
        drive(1, 4, 0, 0, 0, 0, 0, 0);
        sample();
        vectors++; if (Stall !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: stall=%b want 1", Stall); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (Stall !== 1'b0 || IFWrite !== 1'b1 || issue_fire !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out: stall=%b ifwrite=%b fire=%b want 0/1/0", Stall, IFWrite, issue_fire); end
        vectors++; if (busy_vec !== '0 || stall_count !== '0) begin
            errors++; $display("FAIL rst_mid_state: busy=%h cnt=%0d want 0/0", busy_vec, stall_count); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        now = now + 2; model_clear();
        drive(1, 4, 0, 0, 0, 0, 0, 0);
        sample();
        vectors++; if (Stall !== 1'b0 || issue_fire !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after: stall=%b fire=%b want 0/1", Stall, issue_fire); end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        now = 0;
        model_clear();
        test_reset();
        test_load_use();
        test_mul_latency();
        test_mc_unit();
        test_waw();
        test_x0();
        test_flush();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
